// File: rtl/ping_pong_merger_pkg.sv
// Shared constants, FSM encoding and packet-length helper for the ping-pong merger.
package ping_pong_merger_pkg;

  localparam int unsigned DEFAULT_DW     = 512;
  localparam int unsigned BYTES_PER_BEAT = DEFAULT_DW / 8;

  typedef enum logic {
    SEL0 = 1'b0,
    SEL1 = 1'b1
  } sel_state_e;

  // Beats per packet, clamped to at least one so a tiny PACKET_SIZE still frames.
  function automatic logic [15:0] expected_beats(input logic [15:0] packet_size,
                                                 input int unsigned bytes_per_beat = BYTES_PER_BEAT);
    logic [15:0] beats;
    beats = 16'(32'(packet_size) / bytes_per_beat);
    return (beats == 16'd0) ? 16'd1 : beats;
  endfunction

endpackage

// File: rtl/ping_pong_merger_if.sv
// AXI-Stream style handshake bundle used for the merger's inputs and output.
interface ping_pong_merger_if
  import ping_pong_merger_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
);

  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/ping_pong_merger_axis_out_reg.sv
// Single-register stream output stage; loads whenever empty or being drained.
module ping_pong_merger_axis_out_reg
  import ping_pong_merger_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  input  logic          src_last,
  output logic          load_c,
  output logic [DW-1:0] dst_data,
  output logic          dst_last,
  output logic          dst_valid,
  input  logic          dst_ready
);

  assign load_c = !dst_valid || dst_ready;

  // Payload only updates on an actual accept; valid drops when loading nothing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_last  <= 1'b0;
    end else if (load_c) begin
      dst_valid <= src_valid;
      if (src_valid) begin
        dst_data <= src_data;
        dst_last <= src_last;
      end
    end
  end

endmodule

// File: rtl/ping_pong_merger.sv
// Reassembles one frame stream by taking packet groups alternately from two inputs.
module ping_pong_merger
  import ping_pong_merger_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic               clk,
  input  logic               resetn,
  ping_pong_merger_if.slave  AXIS_IN0,
  ping_pong_merger_if.slave  AXIS_IN1,
  ping_pong_merger_if.master AXIS_OUT,
  input  logic [15:0]        PACKET_SIZE,
  input  logic [31:0]        PACKETS_PER_GROUP,
  input  logic               CLEAR,
  output logic               ACTIVE_INPUT,
  output logic [31:0]        GROUP_COUNT,
  output logic               LENGTH_ERR
);

  localparam int unsigned BPB = DW / 8;

  sel_state_e    state;
  sel_state_e    state_next;
  logic          load;
  logic          accept;
  logic          last_accept;
  logic          group_done;
  logic          len_bad;
  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;
  logic [15:0]   beats_e;
  logic [15:0]   beat_cnt;
  logic [31:0]   pkts_p;
  logic [31:0]   pkt_cnt;

  assign beats_e     = expected_beats(PACKET_SIZE, BPB);
  assign pkts_p      = (PACKETS_PER_GROUP == 32'd0) ? 32'd1 : PACKETS_PER_GROUP;
  assign accept      = sel_valid && load;
  assign last_accept = accept && sel_last;
  // >= keeps the arbiter moving even if the group size is lowered mid-group.
  assign group_done  = last_accept && (pkt_cnt >= pkts_p);
  assign len_bad     = sel_last ? (beat_cnt != beats_e) : (beat_cnt >= beats_e);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= SEL0;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEL0: if (group_done) state_next = SEL1;
      SEL1: if (group_done) state_next = SEL0;
    endcase
  end

  // Only the selected input ever sees ready; the other is never sampled.
  always_comb begin
    ACTIVE_INPUT    = 1'b0;
    AXIS_IN0.tready = 1'b0;
    AXIS_IN1.tready = 1'b0;
    sel_valid       = AXIS_IN0.tvalid;
    sel_last        = AXIS_IN0.tlast;
    sel_data        = AXIS_IN0.tdata;
    case (state)
      SEL0: AXIS_IN0.tready = load;
      SEL1: begin
        ACTIVE_INPUT    = 1'b1;
        AXIS_IN1.tready = load;
        sel_valid       = AXIS_IN1.tvalid;
        sel_last        = AXIS_IN1.tlast;
        sel_data        = AXIS_IN1.tdata;
      end
    endcase
  end

  // Beat position saturates at E on overlong packets; packet index wraps per group.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= 16'd1;
      pkt_cnt  <= 32'd1;
    end else if (accept) begin
      if (sel_last)                 beat_cnt <= 16'd1;
      else if (beat_cnt >= beats_e) beat_cnt <= beats_e;
      else                          beat_cnt <= 16'(beat_cnt + 16'd1);
      if (sel_last)                 pkt_cnt  <= (pkt_cnt >= pkts_p) ? 32'd1 : 32'(pkt_cnt + 32'd1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      GROUP_COUNT <= 32'd0;
      LENGTH_ERR  <= 1'b0;
    end else if (CLEAR) begin
      GROUP_COUNT <= 32'd0;
      LENGTH_ERR  <= 1'b0;
    end else begin
      if (group_done)        GROUP_COUNT <= 32'(GROUP_COUNT + 32'd1);
      if (accept && len_bad) LENGTH_ERR  <= 1'b1;
    end
  end

  ping_pong_merger_axis_out_reg #(.DW(DW)) u_out_reg (
    .clk       (clk),
    .resetn    (resetn),
    .src_valid (sel_valid),
    .src_data  (sel_data),
    .src_last  (sel_last),
    .load_c    (load),
    .dst_data  (AXIS_OUT.tdata),
    .dst_last  (AXIS_OUT.tlast),
    .dst_valid (AXIS_OUT.tvalid),
    .dst_ready (AXIS_OUT.tready)
  );

endmodule

// File: tb/tb_ping_pong_merger.sv
// Self-checking bench: merged order predicted from packet-group rules, random ready and decoy traffic.
module tb_ping_pong_merger;

  localparam int unsigned DW = 512;

  typedef struct packed {
    logic        src;
    logic        last;
    logic        bad;
    logic        gend;
    logic [31:0] tag;
  } beat_t;

  typedef struct {
    int psize;
    int ppg;
    int groups;
    bit rnd;
    bit cf;
    int stall;
    int exp_cycles;
    int exp_groups;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] packet_size;
  logic [31:0] ppg;
  logic        clear;
  logic        active_input;
  logic [31:0] group_count;
  logic        length_err;

  ping_pong_merger_if #(.DW(DW)) in0_if ();
  ping_pong_merger_if #(.DW(DW)) in1_if ();
  ping_pong_merger_if #(.DW(DW)) out_if ();

  ping_pong_merger #(.DW(DW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .AXIS_IN0          (in0_if),
    .AXIS_IN1          (in1_if),
    .AXIS_OUT          (out_if),
    .PACKET_SIZE       (packet_size),
    .PACKETS_PER_GROUP (ppg),
    .CLEAR             (clear),
    .ACTIVE_INPUT      (active_input),
    .GROUP_COUNT       (group_count),
    .LENGTH_ERR        (length_err)
  );

  always #5 clk = ~clk;

  beat_t exp_in_q[$];
  beat_t exp_out_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    seq_no   = 0;
  int    grp_exp  = 0;
  bit    err_exp  = 1'b0;
  bit    active_exp = 1'b0;
  bit    rnd_ready  = 1'b0;
  bit    cf_on      = 1'b0;
  int    stall_cnt  = 0;
  int    stall_age  = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
  endtask

  function automatic logic [DW-1:0] data_of(input logic [31:0] tag);
    return {16{tag}};
  endfunction

  // Packet of len beats; flags where the length rule against E is first broken.
  task automatic add_packet(input bit src, input int len, input int e, input bit last_of_group);
    beat_t bt;
    for (int b = 1; b <= len; b++) begin
      bt.src  = src;
      bt.last = (b == len);
      bt.bad  = ((b == len) && (len < e)) || ((b == e) && (len > e));
      bt.gend = (b == len) && last_of_group;
      bt.tag  = 32'(seq_no);
      seq_no++;
      exp_in_q.push_back(bt);
      exp_out_q.push_back(bt);
    end
  endtask

  task automatic add_groups(input int n, input int p, input int e);
    for (int g = 0; g < n; g++) begin
      for (int k = 0; k < p; k++) add_packet(active_exp, e, e, k == p - 1);
      active_exp = !active_exp;
    end
  endtask

  task automatic drive(input bit s, input bit v, input logic [DW-1:0] d, input bit l);
    if (s) begin
      in1_if.tvalid = v; in1_if.tdata = d; in1_if.tlast = l;
    end else begin
      in0_if.tvalid = v; in0_if.tdata = d; in0_if.tlast = l;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear   = 1'b0;
    grp_exp = 0;
    err_exp = 1'b0;
  endtask

  // One clock: drive at negedge, check settled outputs, predict handshakes, advance.
  task automatic one_cycle();
    bit            have;
    bit            hsrc;
    bit            stalled;
    bit            in_fire;
    beat_t         h;
    beat_t         o;
    logic [DW-1:0] cf_data;
    have    = exp_in_q.size() > 0;
    h       = have ? exp_in_q[0] : '0;
    hsrc    = have ? h.src : active_exp;
    stalled = have && hsrc && (stall_cnt > 0);
    if (stalled) begin
      stall_cnt--;
      stall_age++;
    end
    out_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    cf_data = {16{32'h8000_0000 | $urandom}};
    drive(hsrc, have && !stalled, data_of(h.tag), h.last);
    drive(!hsrc, cf_on, cf_data, 1'($urandom_range(0, 1)));
    #1;
    check(active_input == hsrc, "active_input", 64'(active_input), 64'(hsrc));
    check((hsrc ? in0_if.tready : in1_if.tready) == 1'b0, "unselected_tready",
          64'(hsrc ? in0_if.tready : in1_if.tready), 64'd0);
    check(length_err == err_exp, "length_err", 64'(length_err), 64'(err_exp));
    check(group_count == 32'(grp_exp), "group_count", 64'(group_count), 64'(grp_exp));
    if (stalled && stall_age >= 2)
      check(out_if.tvalid == 1'b0, "stall_out_valid", 64'(out_if.tvalid), 64'd0);
    if (out_if.tvalid && out_if.tready) begin
      if (exp_out_q.size() == 0) begin
        check(1'b0, "extra_out_beat", 64'(out_if.tdata[31:0]), 64'd0);
      end else begin
        o = exp_out_q.pop_front();
        check(out_if.tdata == data_of(o.tag), "out_data", 64'(out_if.tdata[31:0]), 64'(o.tag));
        check(out_if.tlast == o.last, "out_last", 64'(out_if.tlast), 64'(o.last));
      end
    end
    in_fire = have && !stalled && (hsrc ? in1_if.tready : in0_if.tready);
    if (in_fire) begin
      void'(exp_in_q.pop_front());
      err_exp = err_exp | h.bad;
      if (h.gend) grp_exp++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_traffic(input int budget, input int stop_left, output int cycles);
    cycles = 0;
    while ((stop_left > 0) ? (exp_in_q.size() > stop_left) : (exp_out_q.size() > 0)) begin
      if (cycles >= budget) begin
        check(1'b0, "cycle_budget", 64'(cycles), 64'(budget));
        break;
      end
      one_cycle();
      cycles++;
    end
  endtask

  vec_t vecs[4];
  int   cyc;
  int   e_eff;
  int   p_eff;

  initial begin
    resetn        = 1'b0;
    clear         = 1'b0;
    packet_size   = 16'd256;
    ppg           = 32'd2;
    out_if.tready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    check(out_if.tvalid == 1'b0, "rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check(out_if.tdata == '0, "rst_tdata", 64'(out_if.tdata[63:0]), 64'd0);
    check(out_if.tlast == 1'b0, "rst_tlast", 64'(out_if.tlast), 64'd0);
    check(active_input == 1'b0, "rst_active", 64'(active_input), 64'd0);
    check(group_count == 32'd0, "rst_groups", 64'(group_count), 64'd0);
    check(length_err == 1'b0, "rst_len_err", 64'(length_err), 64'd0);
    resetn = 1'b1;

    // psize, ppg, groups, random ready, decoy on idle input, in1 stall, cycles, groups
    vecs[0] = '{256, 2, 4, 1'b0, 1'b1, 0,  33, 4};
    vecs[1] = '{256, 2, 4, 1'b1, 1'b1, 0,  0,  4};
    vecs[2] = '{256, 2, 2, 1'b0, 1'b1, 20, 0,  2};
    vecs[3] = '{32,  0, 8, 1'b0, 1'b1, 0,  9,  8};

    for (int i = 0; i < 4; i++) begin
      packet_size = 16'(vecs[i].psize);
      ppg         = 32'(vecs[i].ppg);
      rnd_ready   = vecs[i].rnd;
      cf_on       = vecs[i].cf;
      stall_cnt   = vecs[i].stall;
      stall_age   = 0;
      seq_no      = 0;
      clear_pulse();
      e_eff = vecs[i].psize / 64;
      if (e_eff == 0) e_eff = 1;
      p_eff = (vecs[i].ppg == 0) ? 1 : vecs[i].ppg;
      add_groups(vecs[i].groups, p_eff, e_eff);
      run_traffic(2000, 0, cyc);
      idle();
      if (vecs[i].exp_cycles != 0)
        check(cyc == vecs[i].exp_cycles, "row_cycles", 64'(cyc), 64'(vecs[i].exp_cycles));
      check(group_count == 32'(vecs[i].exp_groups), "row_groups", 64'(group_count), 64'(vecs[i].exp_groups));
      check(active_input == 1'b0, "row_active", 64'(active_input), 64'd0);
      check(length_err == 1'b0, "row_len_err", 64'(length_err), 64'd0);
    end

    // Short packet (3 of 4 beats) still closes the group and flags the error.
    packet_size = 16'd256;
    ppg         = 32'd2;
    rnd_ready   = 1'b0;
    cf_on       = 1'b1;
    stall_cnt   = 0;
    clear_pulse();
    add_packet(1'b0, 3, 4, 1'b0);
    add_packet(1'b0, 4, 4, 1'b1);
    active_exp = 1'b1;
    run_traffic(500, 0, cyc);
    idle();
    check(length_err == 1'b1, "short_len_err", 64'(length_err), 64'd1);
    check(group_count == 32'd1, "short_groups", 64'(group_count), 64'd1);
    check(active_input == 1'b1, "short_active", 64'(active_input), 64'd1);
    clear_pulse();
    check(length_err == 1'b0, "clear_len_err", 64'(length_err), 64'd0);
    check(group_count == 32'd0, "clear_groups", 64'(group_count), 64'd0);
    // Overlong packet (5 of 4 beats) on input 1.
    add_packet(1'b1, 4, 4, 1'b0);
    add_packet(1'b1, 5, 4, 1'b1);
    active_exp = 1'b0;
    run_traffic(500, 0, cyc);
    idle();
    check(length_err == 1'b1, "long_len_err", 64'(length_err), 64'd1);
    check(group_count == 32'd1, "long_groups", 64'(group_count), 64'd1);
    check(active_input == 1'b0, "long_active", 64'(active_input), 64'd0);

    // Reset asserted while input 1 is two beats into its first packet.
    clear_pulse();
    seq_no = 0;
    add_groups(2, 2, 4);
    run_traffic(500, 6, cyc);
    #2 resetn = 1'b0;
    #1;
    check(out_if.tvalid == 1'b0, "async_rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check(out_if.tdata == '0, "async_rst_tdata", 64'(out_if.tdata[63:0]), 64'd0);
    check(active_input == 1'b0, "async_rst_active", 64'(active_input), 64'd0);
    check(group_count == 32'd0, "async_rst_groups", 64'(group_count), 64'd0);
    idle();
    @(negedge clk);
    resetn = 1'b1;
    exp_in_q.delete();
    exp_out_q.delete();
    active_exp = 1'b0;
    grp_exp    = 0;
    err_exp    = 1'b0;
    add_groups(1, 2, 4);
    run_traffic(500, 0, cyc);
    idle();
    check(group_count == 32'd1, "post_rst_groups", 64'(group_count), 64'd1);
    check(active_input == 1'b1, "post_rst_active", 64'(active_input), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
